ghash_ctrl: RTL and testbench



---
 rtl/ghash_pkg.sv | 18 +
 rtl/ghash_if.sv | 24 ++
 rtl/gfm.sv | 66 ++++++
 rtl/ghash_ctrl.sv | 107 ++++++++++
 tb/tb_ghash_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH controller and its GF(2^128) multiplier.
package ghash_pkg;

    localparam int unsigned GFM_BITS_DEF   = 128;
    localparam int unsigned GFM_CYCLES_DEF = 8;

    // Low-order terms of x^128 + x^7 + x^2 + x + 1, folded back in on overflow.
    localparam logic [127:0] GCM_POLY = 128'h87;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_MUL    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

endpackage

// File: rtl/ghash_if.sv
// Block input stream and tag output stream of the GHASH controller.
interface ghash_if
    import ghash_pkg::*;
#(
    parameter int unsigned BITS = GFM_BITS_DEF
);
    logic [BITS-1:0] s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [BITS-1:0] tag;
    logic            tag_valid;
    logic            tag_ready;

    modport master (
        output s_data, s_valid, s_last, tag_ready,
        input  s_ready, tag, tag_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, tag_ready,
        output s_ready, tag, tag_valid
    );
endinterface

// File: rtl/gfm.sv
// Iterative GF(2^GFM_BITS) multiplier: GFM_BITS/GFM_CYCLES bits of a per clock, MSB first.
module gfm
    import ghash_pkg::*;
#(
    parameter int unsigned GFM_BITS   = GFM_BITS_DEF,
    parameter int unsigned GFM_CYCLES = GFM_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [GFM_BITS-1:0] a,
    input  logic [GFM_BITS-1:0] b,
    output logic [GFM_BITS-1:0] result,
    output logic                done
);
    localparam int unsigned STEP = GFM_BITS / GFM_CYCLES;
    localparam int unsigned CW   = (GFM_CYCLES > 1) ? $clog2(GFM_CYCLES) : 1;
    localparam logic [GFM_BITS-1:0] POLY = GFM_BITS'(GCM_POLY);

    logic [GFM_BITS-1:0] a_q;
    logic [GFM_BITS-1:0] b_q;
    logic [GFM_BITS-1:0] acc_next;
    logic [CW-1:0]       cnt;
    logic                active;

    function automatic logic [GFM_BITS-1:0] mul_x(input logic [GFM_BITS-1:0] v);
        return {v[GFM_BITS-2:0], 1'b0} ^ (v[GFM_BITS-1] ? POLY : '0);
    endfunction

    // Horner step over the next STEP bits of a.
    always_comb begin
        acc_next = result;
        for (int unsigned i = 0; i < STEP; i++) begin
            acc_next = mul_x(acc_next) ^ (a_q[GFM_BITS-1-i] ? b_q : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en && !active) begin
                a_q    <= a;
                b_q    <= b;
                result <= '0;
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                result <= acc_next;
                a_q    <= a_q << STEP;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(GFM_CYCLES - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH running digest Y_i = (Y_{i-1} ^ X_i) * H, one gfm multiply per accepted block.
module ghash_ctrl
    import ghash_pkg::*;
#(
    parameter int unsigned GFM_BITS   = GFM_BITS_DEF,
    parameter int unsigned GFM_CYCLES = GFM_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                h_load,
    input  logic [GFM_BITS-1:0] h_key,
    output logic                busy,
    ghash_if.slave              bus
);
    state_t              state;
    logic [GFM_BITS-1:0] h;
    logic [GFM_BITS-1:0] y;
    logic [GFM_BITS-1:0] op_a;
    logic [GFM_BITS-1:0] gfm_result;
    logic                h_valid;
    logic                last_q;
    logic                gfm_en;
    logic                gfm_done;

    gfm #(
        .GFM_BITS   (GFM_BITS),
        .GFM_CYCLES (GFM_CYCLES)
    ) u_gfm (
        .clk    (clk),
        .reset  (reset),
        .en     (gfm_en),
        .a      (op_a),
        .b      (h),
        .result (gfm_result),
        .done   (gfm_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.s_ready   <= 1'b0;
            bus.tag_valid <= 1'b0;
            bus.tag       <= '0;
            busy          <= 1'b0;
            y             <= '0;
            h             <= '0;
            h_valid       <= 1'b0;
            op_a          <= '0;
            last_q        <= 1'b0;
            gfm_en        <= 1'b0;
        end else begin
            gfm_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (h_load) begin
                        h           <= h_key;
                        h_valid     <= 1'b1;
                        bus.s_ready <= 1'b1;
                        state       <= ST_ACCEPT;
                    end
                end
                // A block handshake wins over a coincident key load.
                ST_ACCEPT: begin
                    if (bus.s_valid && h_valid) begin
                        op_a        <= y ^ bus.s_data;
                        last_q      <= bus.s_last;
                        busy        <= 1'b1;
                        bus.s_ready <= 1'b0;
                        gfm_en      <= 1'b1;
                        state       <= ST_MUL;
                    end else if (h_load && !busy) begin
                        h <= h_key;
                    end
                end
                ST_MUL: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gfm_done) begin
                        y <= gfm_result;
                        if (last_q) begin
                            bus.tag       <= gfm_result;
                            bus.tag_valid <= 1'b1;
                            state         <= ST_OUT;
                        end else begin
                            bus.s_ready <= 1'b1;
                            state       <= ST_ACCEPT;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.tag_ready) begin
                        bus.tag_valid <= 1'b0;
                        y             <= '0;
                        busy          <= 1'b0;
                        bus.s_ready   <= 1'b1;
                        state         <= ST_ACCEPT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: directed scenarios plus randomized messages vs a GF(2^128) model.
module tb_ghash_ctrl;
    import ghash_pkg::*;

    localparam int unsigned W = 128;
    localparam int unsigned G = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         h_load = 1'b0;
    logic [W-1:0] h_key = '0;
    logic         busy;

    ghash_if #(.BITS(W)) bus ();

    ghash_ctrl #(
        .GFM_BITS   (W),
        .GFM_CYCLES (G)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .h_load (h_load),
        .h_key  (h_key),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_h;
    logic [W-1:0] m_y;
    logic [W-1:0] exp_q[$];
    int           tr_mode = 0;  // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shift-and-add product in GF(2^128), bit i = coefficient of x^i.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] acc;
        logic [W-1:0] v;
        acc = '0;
        v   = x;
        for (int i = 0; i < int'(W); i++) begin
            if (z[i]) acc = acc ^ v;
            if (v[W-1]) v = (v << 1) ^ W'(128'h87);
            else        v = v << 1;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always begin
        @(posedge clk);
        #2;
        case (tr_mode)
            1:       bus.tag_ready = 1'b0;
            2:       bus.tag_ready = 1'b1;
            default: bus.tag_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Tag monitor: pops the scoreboard on every tag handshake and checks hold stability.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_tag = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("tag_valid_hold", W'(bus.tag_valid), W'(1));
                chk("tag_hold", bus.tag, prev_tag);
            end
            if (bus.tag_valid && bus.tag_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tag_unexpected: got %h with no tag expected", bus.tag);
                end else begin
                    chk("tag", bus.tag, exp_q.pop_front());
                end
            end
            prev_hold = bus.tag_valid && !bus.tag_ready;
            prev_tag  = bus.tag;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(dut.u_gfm.done && dut.state != ST_WAIT))
                else $error("gfm done outside WAIT");
            assert (!(dut.u_gfm.en && dut.u_gfm.active))
                else $error("gfm en during compute");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    task automatic load_h(input logic [W-1:0] key, input bit honoured);
        h_load = 1'b1;
        h_key  = key;
        @(negedge clk);
        h_load = 1'b0;
        if (honoured) m_h = key;
    endtask

    // Presents one block, then checks the not-ready window and the cycle that follows it.
    task automatic send_block(input logic [W-1:0] d, input logic last, input bit load_too,
                              input logic [W-1:0] key, output int hs);
        int  n;
        bit  gap_ok;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        if (load_too) begin
            h_load = 1'b1;
            h_key  = key;
        end
        n = 0;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        if (!bus.s_ready) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: got 0 expected 1 within 200 cycles");
            bus.s_valid = 1'b0;
            h_load      = 1'b0;
            return;
        end
        m_y = gf_mul(m_y ^ d, m_h);
        if (last) begin
            exp_q.push_back(m_y);
            m_y = '0;
        end
        gap_ok = 1'b1;
        for (int k = 0; k < int'(G) + 2; k++) begin
            @(negedge clk);
            h_load = 1'b0;
            if (bus.s_ready !== 1'b0 || busy !== 1'b1 || bus.tag_valid !== 1'b0) gap_ok = 1'b0;
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = rand128();
            bus.s_last  = 1'($urandom_range(0, 1));
        end
        chk("busy_window", W'(gap_ok), W'(1));
        @(negedge clk);
        bus.s_valid = 1'b0;
        if (last) begin
            chk("tag_valid_rise", W'(bus.tag_valid), W'(1));
            chk("s_ready_in_out", W'(bus.s_ready), W'(0));
        end else begin
            chk("s_ready_period", W'(bus.s_ready), W'(1));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d tags outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    int  hs;
    int  hs1;
    int  hs2;
    int  c0;
    int  nb;
    bit  ok;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        m_h = '0;
        m_y = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", W'(bus.s_ready), W'(0));
        chk("rst_tag_valid", W'(bus.tag_valid), W'(0));
        chk("rst_tag", bus.tag, '0);
        chk("rst_busy", W'(busy), W'(0));
        repeat (3) @(negedge clk);
        chk("idle_no_h", W'(bus.s_ready), W'(0));

        // H=1: blocks 5, 3 -> 6; latency and period
        tr_mode = 1;
        load_h(W'(1), 1);
        chk("idle_to_accept", W'(bus.s_ready), W'(1));
        send_block(W'(5), 1'b0, 1'b0, '0, hs1);
        send_block(W'(3), 1'b1, 1'b0, '0, hs2);
        chk("block_period", W'(hs2 - hs1), W'(G + 3));
        chk("tag_latency", W'(cyc - hs1), W'(2 * (G + 3)));
        chk("tag_a_value", bus.tag, W'(6));
        tr_mode = 2;
        wait_drain(50);

        // H=2: x^127 * x reduces to 0x87; busy drop timing
        load_h(W'(2), 1);
        send_block({1'b1, {(W - 1){1'b0}}}, 1'b1, 1'b0, '0, hs);
        chk("busy_at_tag_hs", W'(busy), W'(1));
        @(negedge clk);
        chk("busy_after_tag", W'(busy), W'(0));
        chk("tag_valid_after", W'(bus.tag_valid), W'(0));
        chk("s_ready_after", W'(bus.s_ready), W'(1));
        wait_drain(20);

        // H=2: blocks 1, 1 -> 6 with tag_ready held low
        tr_mode = 1;
        send_block(W'(1), 1'b0, 1'b0, '0, hs);
        send_block(W'(1), 1'b1, 1'b0, '0, hs);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.tag_valid !== 1'b1 || bus.tag !== W'(6)) ok = 1'b0;
        end
        chk("tag_stall_stable", W'(ok), W'(1));
        tr_mode = 2;
        wait_drain(20);

        // Back-to-back: second message right after the tag handshake
        load_h(W'(1), 1);
        send_block(rand128(), 1'b1, 1'b0, '0, hs);
        @(negedge clk);
        c0 = cyc;
        send_block(W'(10), 1'b1, 1'b0, '0, hs);
        chk("b2b_immediate", W'(hs - c0), W'(0));
        wait_drain(20);

        // Key loads while busy or coincident with a handshake are ignored
        tr_mode = 1;
        load_h(rand128(), 1);
        send_block(rand128(), 1'b0, 1'b1, rand128(), hs);
        load_h(rand128(), 0);
        send_block(rand128(), 1'b1, 1'b0, '0, hs);
        load_h(rand128(), 0);
        tr_mode = 2;
        wait_drain(20);
        load_h(rand128(), 1);
        send_block(rand128(), 1'b0, 1'b0, '0, hs);
        send_block(rand128(), 1'b1, 1'b0, '0, hs);
        wait_drain(20);

        // Reset while the multiplier is running
        bus.s_data  = rand128();
        bus.s_last  = 1'b0;
        bus.s_valid = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_y = '0;
        exp_q.delete();
        chk("wrst_s_ready", W'(bus.s_ready), W'(0));
        chk("wrst_tag_valid", W'(bus.tag_valid), W'(0));
        chk("wrst_tag", bus.tag, '0);
        chk("wrst_busy", W'(busy), W'(0));
        ok = 1'b1;
        repeat (G + 6) begin
            @(negedge clk);
            if (bus.s_ready !== 1'b0 || bus.tag_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("wrst_quiet", W'(ok), W'(1));
        load_h(rand128(), 1);
        chk("wrst_reload", W'(bus.s_ready), W'(1));
        send_block(rand128(), 1'b0, 1'b0, '0, hs);
        send_block(rand128(), 1'b1, 1'b0, '0, hs);
        wait_drain(20);

        // Randomized messages
        for (int m = 0; m < 40; m++) begin
            tr_mode = 0;
            if ($urandom_range(0, 1) == 1) load_h(rand128(), 1);
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_block(rand128(), 1'(b == nb - 1), 1'b0, '0, hs);
                if (b != nb - 1 && $urandom_range(0, 3) == 0) load_h(rand128(), 0);
            end
            wait_drain(300);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
